alu_control_unit: RTL and testbench

- Decoder and sequencer on the driving side of the 32-bit ALU: turns the main-control ALUOp and R-type Funct into the registered 4-bit ALUControl code the ALU consumes.
- Also executes MULT/MULTU, which the ALU cannot perform, as an iterative 32-cycle shift-add into HI/LO.
- Sits between the main control decoder and the ALU in the EX stage; stalls upstream via InReady while a multiply runs.

---
 rtl/alu_defs_pkg.sv | 56 +++++
 rtl/alu_control_unit_if.sv | 28 ++
 rtl/alu_control_unit_mul_seq.sv | 88 ++++++++
 rtl/alu_control_unit.sv | 87 ++++++++
 tb/tb_alu_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - ALUOp, Funct and ALUControl encodings shared by the EX-stage control and the ALU
package alu_defs_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_ORI = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_NOP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mul_funct(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU);
  endfunction

  // Unsupported R-type functs decode to NOP; the caller flags them as illegal.
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = ALUC_NOP;
    case (op)
      ALUOP_MEM: code = ALUC_ADD;
      ALUOP_BR:  code = ALUC_SUB;
      ALUOP_ORI: code = ALUC_OR;
      default: begin
        case (fn)
          FN_ADD:  code = ALUC_ADD;
          FN_SUB:  code = ALUC_SUB;
          FN_AND:  code = ALUC_AND;
          FN_OR:   code = ALUC_OR;
          FN_SLT:  code = ALUC_SLT;
          default: code = ALUC_NOP;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// rtl/alu_control_unit_if.sv - request/response bundle between main control, ALU control and HI/LO consumers
interface alu_control_unit_if #(parameter int WIDTH = 32);

  logic             InValid;
  logic             InReady;
  logic [1:0]       ALUOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             OutValid;
  logic             IllegalOp;
  logic             Busy;
  logic             MulDone;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output InValid, ALUOp, Funct, A, B,
    input  InReady, ALUControl, OutValid, IllegalOp, Busy, MulDone, HI, LO
  );

  modport slave (
    input  InValid, ALUOp, Funct, A, B,
    output InReady, ALUControl, OutValid, IllegalOp, Busy, MulDone, HI, LO
  );

endinterface

// File: rtl/alu_control_unit_mul_seq.sv
// rtl/alu_control_unit_mul_seq.sv - fixed-latency shift-add multiplier with magnitude/sign fixup into HI/LO
module mul_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;

  assign done = run && (cnt_q == CNT_LAST);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // The carry out of the upper-half add shifts back in as the new MSB.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_next = {sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -acc_next : acc_next;

    if (start) begin
      // -x of the most negative value is itself, which is the correct unsigned magnitude.
      mcand_d = (signed_op && a[WIDTH-1]) ? -a : a;
      mplr_d  = (signed_op && b[WIDTH-1]) ? -b : b;
      neg_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d   = '0;
      cnt_d   = '0;
    end else if (run) begin
      acc_d  = acc_next;
      mplr_d = mplr_q >> 1;
      cnt_d  = cnt_q + 1'b1;
      if (done) begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - EX-stage ALU control: registered decode plus sequenced MULT/MULTU into HI/LO
module alu_control_unit
  import alu_defs_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  alu_control_unit_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] aluc_q, aluc_d;
  logic       out_valid_q, out_valid_d;
  logic       illegal_q, illegal_d;
  logic       mul_start;
  logic       mul_last;
  logic       is_mul;

  assign is_mul = (bus.ALUOp == ALUOP_R) && is_mul_funct(bus.Funct);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      aluc_q      <= ALUC_ADD;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aluc_q      <= aluc_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aluc_d      = aluc_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.InValid) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            aluc_d      = alu_decode(bus.ALUOp, bus.Funct);
            out_valid_d = 1'b1;
            illegal_d   = (bus.ALUOp == ALUOP_R) && (aluc_d == ALUC_NOP);
          end
        end
      end
      S_MUL: begin
        if (mul_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  mul_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_seq (
    .clk       (Clk),
    .rst       (Rst),
    .start     (mul_start),
    .run       (state_q == S_MUL),
    .signed_op (bus.Funct == FN_MULT),
    .a         (bus.A),
    .b         (bus.B),
    .done      (mul_last),
    .hi        (bus.HI),
    .lo        (bus.LO)
  );

  assign bus.InReady    = (state_q == S_IDLE) && !Rst;
  assign bus.ALUControl = aluc_q;
  assign bus.OutValid   = out_valid_q;
  assign bus.IllegalOp  = illegal_q;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.MulDone    = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - randomized self-checking bench for alu_control_unit against a behavioural model
module tb_alu_control_unit;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  alu_control_unit_if #(.WIDTH(32)) bus();

  alu_control_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_aluc;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [3:0] legal_cd [5] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7};

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output logic illegal);
    illegal = 1'b0;
    case (op)
      2'd0: code = 4'h2;
      2'd1: code = 4'h6;
      2'd3: code = 4'h1;
      default: begin
        code    = 4'hf;
        illegal = 1'b1;
        for (int i = 0; i < 5; i++)
          if (legal_fn[i] == fn) begin
            code    = legal_cd[i];
            illegal = 1'b0;
          end
      end
    endcase
  endfunction

  function automatic logic [63:0] ref_product(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.InValid = v;
    bus.ALUOp   = op;
    bus.Funct   = fn;
    bus.A       = a;
    bus.B       = b;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    tick();
    tick();
    checks++;
    if (bus.InReady !== 1'b0) begin
      failures++;
      $display("FAIL reset_inready_low: got %b expected 0", bus.InReady);
    end
    Rst = 1'b0;
    #1;
    checks++;
    if (bus.InReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_inready_release: got %b expected 1", bus.InReady);
    end
    drive(1'b1, 2'd2, 6'h24, 32'd0, 32'd0);
    @(posedge Clk);
    #3;
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    Rst = 1'b1;
    #1;
    checks++;
    if (bus.ALUControl !== 4'h2 || bus.OutValid !== 1'b0 || bus.IllegalOp !== 1'b0 ||
        bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0 || bus.MulDone !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_clear: got aluc=%h ov=%b il=%b hi=%h lo=%h busy=%b md=%b expected 2 0 0 0 0 0 0",
               bus.ALUControl, bus.OutValid, bus.IllegalOp, bus.HI, bus.LO, bus.Busy, bus.MulDone);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    checks++;
    if (bus.InReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_inready_after: got %b expected 1", bus.InReady);
    end
    exp_aluc = 4'h2;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
  endtask

  task automatic test_decode_sweep();
    logic [1:0] ops [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
    for (int i = 0; i < 8; i++) begin
      fn = (i < 5) ? legal_fn[i] : 6'($urandom);
      drive(1'b1, ops[i], fn, $urandom, $urandom);
      ref_decode(ops[i], fn, code, ill);
      tick();
      exp_aluc = code;
      checks++;
      if (bus.ALUControl !== exp_aluc || bus.OutValid !== 1'b1 || bus.IllegalOp !== ill) begin
        failures++;
        $display("FAIL decode_%0d: got aluc=%h ov=%b il=%b expected aluc=%h ov=1 il=%b",
                 i, bus.ALUControl, bus.OutValid, bus.IllegalOp, exp_aluc, ill);
      end
    end
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    tick();
    checks++;
    if (bus.OutValid !== 1'b0 || bus.ALUControl !== exp_aluc) begin
      failures++;
      $display("FAIL decode_idle: got ov=%b aluc=%h expected ov=0 aluc=%h", bus.OutValid, bus.ALUControl, exp_aluc);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'd2, 6'h00, 32'd0, 32'd0);
    tick();
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    exp_aluc = 4'hf;
    checks++;
    if (bus.ALUControl !== 4'hf || bus.OutValid !== 1'b1 || bus.IllegalOp !== 1'b1) begin
      failures++;
      $display("FAIL illegal_pulse: got aluc=%h ov=%b il=%b expected f 1 1", bus.ALUControl, bus.OutValid, bus.IllegalOp);
    end
    tick();
    checks++;
    if (bus.ALUControl !== 4'hf || bus.OutValid !== 1'b0 || bus.IllegalOp !== 1'b0) begin
      failures++;
      $display("FAIL illegal_one_cycle: got aluc=%h ov=%b il=%b expected f 0 0", bus.ALUControl, bus.OutValid, bus.IllegalOp);
    end
  endtask

  task automatic run_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit hold_simple);
    logic [63:0] p;
    int  cyc;
    int  low_cnt;
    bit  seen;
    bit  stray_ov;
    bit  early_hilo;
    p = ref_product(sgn, a, b);
    drive(1'b1, 2'd2, sgn ? 6'h18 : 6'h19, a, b);
    tick();
    if (hold_simple) drive(1'b1, 2'd2, 6'h2a, $urandom, $urandom);
    else             drive(1'b0, 2'd2, 6'h18, $urandom, $urandom);
    cyc = 1; low_cnt = 0; seen = 0; stray_ov = 0; early_hilo = 0;
    while (!seen && cyc <= 40) begin
      if (bus.InReady === 1'b0) low_cnt++;
      if (bus.OutValid !== 1'b0) stray_ov = 1;
      if (bus.MulDone === 1'b1) seen = 1;
      else begin
        if (bus.HI !== exp_hi || bus.LO !== exp_lo) early_hilo = 1;
        tick();
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != 33) begin
      failures++;
      $display("FAIL mul_done_cycle: got seen=%b cycle=%0d expected seen=1 cycle=33", seen, cyc);
    end
    checks++;
    if (low_cnt != 33 || stray_ov || early_hilo) begin
      failures++;
      $display("FAIL mul_busy_window: got inready_low=%0d stray_ov=%b early_hilo=%b expected 33 0 0",
               low_cnt, stray_ov, early_hilo);
    end
    checks++;
    if (bus.HI !== p[63:32] || bus.LO !== p[31:0] || bus.Busy !== 1'b1 || bus.ALUControl !== exp_aluc) begin
      failures++;
      $display("FAIL mul_result a=%h b=%h s=%0d: got hi=%h lo=%h busy=%b aluc=%h expected hi=%h lo=%h busy=1 aluc=%h",
               a, b, sgn, bus.HI, bus.LO, bus.Busy, bus.ALUControl, p[63:32], p[31:0], exp_aluc);
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    tick();
    checks++;
    if (bus.MulDone !== 1'b0 || bus.InReady !== 1'b1 || bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin
      failures++;
      $display("FAIL mul_return_idle: got md=%b rdy=%b busy=%b ov=%b expected 0 1 0 0",
               bus.MulDone, bus.InReady, bus.Busy, bus.OutValid);
    end
    if (hold_simple) begin
      tick();
      drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
      exp_aluc = 4'h7;
      checks++;
      if (bus.OutValid !== 1'b1 || bus.ALUControl !== 4'h7 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
        failures++;
        $display("FAIL mul_held_op: got ov=%b aluc=%h hi=%h lo=%h expected 1 7 %h %h",
                 bus.OutValid, bus.ALUControl, bus.HI, bus.LO, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_mult();
    run_mul(1'b1, 32'd7, 32'hFFFFFFFD, 1'b0);
    checks++;
    if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL mult_7x-3: got hi=%h lo=%h expected ffffffff ffffffeb", bus.HI, bus.LO);
    end
  endtask

  task automatic test_multu_hold();
    run_mul(1'b0, 32'hFFFFFFFF, 32'd2, 1'b1);
    checks++;
    if (bus.HI !== 32'h00000001 || bus.LO !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL multu_max_x2: got hi=%h lo=%h expected 00000001 fffffffe", bus.HI, bus.LO);
    end
  endtask

  task automatic test_mul_random();
    run_mul(1'b1, 32'h80000000, 32'd3, 1'b0);
    run_mul(1'b1, 32'h80000000, 32'h80000000, 1'b0);
    run_mul(1'b0, 32'd0, $urandom, 1'b0);
    run_mul(1'b1, $urandom, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_mul(1'($urandom), $urandom, $urandom, 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic       v;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
    for (int i = 0; i < 40; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom);
      fn = ($urandom_range(0, 2) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      if (fn == 6'h18 || fn == 6'h19) fn = 6'h3f;
      drive(v, op, fn, $urandom, $urandom);
      ref_decode(op, fn, code, ill);
      tick();
      if (v) exp_aluc = code;
      checks++;
      if (bus.ALUControl !== exp_aluc || bus.OutValid !== v || bus.IllegalOp !== (v & ill) ||
          bus.HI !== exp_hi || bus.LO !== exp_lo || bus.InReady !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d: got aluc=%h ov=%b il=%b hi=%h lo=%h rdy=%b expected aluc=%h ov=%b il=%b hi=%h lo=%h rdy=1",
                 i, bus.ALUControl, bus.OutValid, bus.IllegalOp, bus.HI, bus.LO, bus.InReady,
                 exp_aluc, v, v & ill, exp_hi, exp_lo);
      end
    end
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic test_abort();
    bit spurious;
    run_mul(1'b0, 32'hDEADBEEF, 32'h00001000, 1'b0);
    drive(1'b1, 2'd2, 6'h18, 32'd5, 32'd5);
    tick();
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    repeat (10) tick();
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0 || bus.MulDone !== 1'b0 ||
        bus.InReady !== 1'b0 || bus.ALUControl !== 4'h2) begin
      failures++;
      $display("FAIL abort_clear: got hi=%h lo=%h busy=%b md=%b rdy=%b aluc=%h expected 0 0 0 0 0 2",
               bus.HI, bus.LO, bus.Busy, bus.MulDone, bus.InReady, bus.ALUControl);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    exp_aluc = 4'h2;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.MulDone !== 1'b0 || bus.Busy !== 1'b0 || bus.InReady !== 1'b1) spurious = 1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL abort_no_muldone: got spurious activity=1 expected 0");
    end
    run_mul(1'b1, 32'd5, 32'd5, 1'b0);
    checks++;
    if (bus.LO !== 32'd25 || bus.HI !== 32'd0) begin
      failures++;
      $display("FAIL abort_reissue: got hi=%h lo=%h expected 0 19", bus.HI, bus.LO);
    end
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_illegal();
    test_mult();
    test_multu_hold();
    test_mul_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
